// File: rtl/ides_sync.sv
// ides_sync: single-clock 1:WIDTH serial-to-parallel deserializer with
// bit-slip word alignment.
//
// One serial bit is sampled on every CLK edge with CE high and assembled into
// WIDTH-bit words. Each completed word is registered on Q, and VALID pulses
// for one cycle. A rising edge on CALIB, seen on a CE cycle, holds the bit
// counter for one sample. This moves the word boundary one bit later.
//
// Ports:
//   CLK      in   sole clock, rising edge
//   RESET    in   synchronous, active-high reset (overrides CE/CALIB/D)
//   CE       in   clock enable; a bit is sampled only when high
//   D        in   serial data
//   CALIB    in   bit-slip request, acts on its rising edge only
//   Q        out  last complete parallel word (registered)
//   VALID    out  one-cycle strobe: Q was updated on this edge
//   SLIP_CNT out  slips applied since reset, modulo WIDTH
module ides_sync #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1,
  parameter logic        INIT      = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             D,
  input  logic             CALIB,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic [3:0]       SLIP_CNT
);

  // Declaration initialisers give the reset state at time zero, so the model
  // is usable even when no reset is applied.
  logic [WIDTH-1:0] sr_q    = '0;
  logic [WIDTH-1:0] sr_d;
  logic [3:0]       cnt_q   = '0;
  logic [3:0]       cnt_d;
  logic             cal_q   = 1'b0;
  logic [WIDTH-1:0] q_q     = {WIDTH{INIT}};
  logic [WIDTH-1:0] q_d;
  logic             valid_q = 1'b0;
  logic             valid_d;
  logic [3:0]       slip_q  = '0;
  logic [3:0]       slip_d;

  logic             slip;
  logic             last_bit;
  logic [WIDTH-1:0] sr_shift;

  // The rising edge is qualified by CE. An edge seen with CE low is dropped
  // and is not held pending.
  assign slip     = CALIB & ~cal_q & CE;
  assign last_bit = (cnt_q == 4'(WIDTH - 1));

  // The word's first bit ends up in Q[0] (LSB_FIRST) or in Q[WIDTH-1].
  generate
    if (LSB_FIRST) begin : g_lsb
      assign sr_shift = {D, sr_q[WIDTH-1:1]};
    end else begin : g_msb
      assign sr_shift = {sr_q[WIDTH-2:0], D};
    end
  endgenerate

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    valid_d = 1'b0;
    slip_d  = slip_q;
    if (CE) begin
      sr_d = sr_shift;
      if (slip) begin
        // The counter holds, so this sample is an extra bit. The word that
        // would have completed here completes on the next CE cycle instead.
        slip_d = (slip_q == 4'(WIDTH - 1)) ? '0 : slip_q + 4'd1;
      end else if (last_bit) begin
        cnt_d   = '0;
        q_d     = sr_shift;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      cal_q   <= 1'b0;
      q_q     <= {WIDTH{INIT}};
      valid_q <= 1'b0;
      slip_q  <= '0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      cal_q   <= CALIB;
      q_q     <= q_d;
      valid_q <= valid_d;
      slip_q  <= slip_d;
    end
  end

  assign Q        = q_q;
  assign VALID    = valid_q;
  assign SLIP_CNT = slip_q;

endmodule

// File: tb/tb_ides_sync.sv
// Bench for ides_sync. Three instances share one stimulus stream:
//   dut_l: LSB_FIRST=1, dut_m: LSB_FIRST=0, dut_i: INIT=1.
// Expected words are queued when a vector is driven and popped when VALID
// is seen.
module tb_ides_sync;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CE = 1'b0;
  logic       D = 1'b0;
  logic       CALIB = 1'b0;
  logic [3:0] q_l, q_m, q_i;
  logic       v_l, v_m, v_i;
  logic [3:0] s_l, s_m, s_i;

  ides_sync #(.WIDTH(4), .LSB_FIRST(1'b1), .INIT(1'b0)) dut_l (
    .CLK(CLK), .RESET(RESET), .CE(CE), .D(D), .CALIB(CALIB),
    .Q(q_l), .VALID(v_l), .SLIP_CNT(s_l));
  ides_sync #(.WIDTH(4), .LSB_FIRST(1'b0), .INIT(1'b0)) dut_m (
    .CLK(CLK), .RESET(RESET), .CE(CE), .D(D), .CALIB(CALIB),
    .Q(q_m), .VALID(v_m), .SLIP_CNT(s_m));
  ides_sync #(.WIDTH(4), .LSB_FIRST(1'b1), .INIT(1'b1)) dut_i (
    .CLK(CLK), .RESET(RESET), .CE(CE), .D(D), .CALIB(CALIB),
    .Q(q_i), .VALID(v_i), .SLIP_CNT(s_i));

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ce, d, cal, ev;
    logic [3:0] eq, em, es;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb_l[$];
  logic [3:0] sb_m[$];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic ce, input logic d, input logic cal, input logic ev,
                      input logic [3:0] eq, input logic [3:0] em, input logic [3:0] es);
    vec_t v;
    v.ce = ce; v.d = d; v.cal = cal; v.ev = ev; v.eq = eq; v.em = em; v.es = es;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic step(input logic ce, input logic d, input logic cal);
    CE = ce; D = d; CALIB = cal;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    RESET = 1'b0;
  endtask

  initial begin
    logic [3:0] last_l, last_m, got;

    // Section A: continuous stream 1,0,1,1 twice.
    for (int unsigned w = 0; w < 2; w++) begin
      addv(1, 1, 0, 0, 4'h0, 4'h0, 4'd0);
      addv(1, 0, 0, 0, 4'h0, 4'h0, 4'd0);
      addv(1, 1, 0, 0, 4'h0, 4'h0, 4'd0);
      addv(1, 1, 0, 1, 4'hD, 4'hB, 4'd0);
    end
    // Section B: CE alternates while 1,0,1,1 is sent.
    addv(1, 1, 0, 0, 4'h0, 4'h0, 4'd0);
    addv(0, 0, 0, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 0, 0, 0, 4'h0, 4'h0, 4'd0);
    addv(0, 0, 0, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 1, 0, 0, 4'h0, 4'h0, 4'd0);
    addv(0, 0, 0, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 1, 0, 1, 4'hD, 4'hB, 4'd0);
    addv(0, 0, 0, 0, 4'h0, 4'h0, 4'd0);
    // Section C: pattern 0001, with a slip on the 2nd bit. Words settle to
    // 4/2. Three more slips wrap SLIP_CNT to 0 and restore 8/1.
    addv(1, 0, 0, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 0, 1, 0, 4'h0, 4'h0, 4'd1);
    addv(1, 0, 0, 0, 4'h0, 4'h0, 4'd1);
    addv(1, 1, 0, 0, 4'h0, 4'h0, 4'd1);
    addv(1, 0, 0, 1, 4'h4, 4'h2, 4'd1);
    for (int unsigned w = 0; w < 2; w++) begin
      addv(1, 0, 0, 0, 4'h0, 4'h0, 4'd1);
      addv(1, 0, 0, 0, 4'h0, 4'h0, 4'd1);
      addv(1, 1, 0, 0, 4'h0, 4'h0, 4'd1);
      addv(1, 0, 0, 1, 4'h4, 4'h2, 4'd1);
    end
    addv(1, 0, 1, 0, 4'h0, 4'h0, 4'd2);
    addv(1, 0, 0, 0, 4'h0, 4'h0, 4'd2);
    addv(1, 1, 1, 0, 4'h0, 4'h0, 4'd3);
    addv(1, 0, 0, 0, 4'h0, 4'h0, 4'd3);
    addv(1, 0, 1, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 0, 0, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 1, 0, 1, 4'h8, 4'h1, 4'd0);
    // Section D: a CALIB edge with CE low is lost. CALIB stays high with CE=1.
    addv(0, 1, 1, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 1, 1, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 0, 1, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 1, 1, 0, 4'h0, 4'h0, 4'd0);
    addv(1, 1, 1, 1, 4'hD, 4'hB, 4'd0);

    // Time-zero state, before any clock edge or reset.
    #1;
    chk("t0_q_l", q_l, 4'h0);
    chk("t0_q_i", q_i, 4'hF);
    chk("t0_valid", v_l, 1'b0);

    do_reset();
    chk("rst_q_l", q_l, 4'h0);
    chk("rst_q_m", q_m, 4'h0);
    chk("rst_q_i", q_i, 4'hF);
    chk("rst_valid", v_l, 1'b0);
    chk("rst_slip", s_l, 4'd0);
    last_l = 4'h0;
    last_m = 4'h0;

    foreach (vecs[i]) begin
      if (vecs[i].ev) begin
        sb_l.push_back(vecs[i].eq);
        sb_m.push_back(vecs[i].em);
        last_l = vecs[i].eq;
        last_m = vecs[i].em;
      end
      step(vecs[i].ce, vecs[i].d, vecs[i].cal);
      chk($sformatf("v%0d_valid_l", i), v_l, vecs[i].ev);
      chk($sformatf("v%0d_valid_m", i), v_m, vecs[i].ev);
      if (v_l) begin
        if (sb_l.size() == 0) chk($sformatf("v%0d_unexpected_l", i), 1, 0);
        else begin got = sb_l.pop_front(); chk($sformatf("v%0d_word_l", i), q_l, got); end
      end
      if (v_m) begin
        if (sb_m.size() == 0) chk($sformatf("v%0d_unexpected_m", i), 1, 0);
        else begin got = sb_m.pop_front(); chk($sformatf("v%0d_word_m", i), q_m, got); end
      end
      chk($sformatf("v%0d_hold_l", i), q_l, last_l);
      chk($sformatf("v%0d_hold_m", i), q_m, last_m);
      chk($sformatf("v%0d_slip", i), s_l, vecs[i].es);
    end
    chk("sb_l_empty", sb_l.size(), 0);
    chk("sb_m_empty", sb_m.size(), 0);

    // Section E: reset after two bits discards the partial word.
    step(1, 1, 0);
    step(1, 1, 0);
    do_reset();
    chk("mid_rst_q_l", q_l, 4'h0);
    chk("mid_rst_q_m", q_m, 4'h0);
    chk("mid_rst_q_i", q_i, 4'hF);
    chk("mid_rst_valid", v_l, 1'b0);
    chk("mid_rst_slip", s_l, 4'd0);
    step(1, 0, 0); chk("e1_valid", v_l, 1'b0);
    step(1, 1, 0); chk("e2_valid", v_l, 1'b0);
    step(1, 1, 0); chk("e3_valid", v_l, 1'b0);
    step(1, 1, 0);
    chk("e4_valid", v_l, 1'b1);
    chk("e4_q_l", q_l, 4'hE);
    chk("e4_q_m", q_m, 4'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
